avalon_master_req_engine: RTL and testbench
===========================================

# avalon_master_req_engine

Synthesizable master-end request engine for the AVMM-over-LVDS bridge. It pops request packets produced by the slave-side bridge from the slave-to-master channel FIFO and replays them as Avalon-MM single or burst transactions on the local bus. It pushes one response packet per request into the master-to-slave channel FIFO. It replaces `avalon_master_stub` in the real design; the channel wiring is identical to the stub's.

## Interface
- MAX_BURST, avmm_lvds_bridge_pkg::MAX_BURST, largest legal burstcount.
- RESP_DEPTH, 2*MAX_BURST, depth in words of the response channel FIFO.
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  reset, synchronous and active-high.
- req_rdreq_o  out  1  pop one word from the request FIFO. The FIFO is show-ahead: req_q_i is valid whenever req_rdempty_i is low.
- req_q_i  in  32  head word of the request FIFO.
- req_rdempty_i  in  1  request FIFO is empty.
- req_rdusedw_i  in  $clog2(MAX_BURST)+1  number of words in the request FIFO.
- resp_data_o  out  32  response word.
- resp_valid_o  out  1  write resp_data_o into the response FIFO this cycle.
- resp_wrusedw_i  in  $clog2(RESP_DEPTH)+1  number of words in the response FIFO.
- avm_address_o  out  32  Avalon byte address.
- avm_burstcount_o  out  $clog2(MAX_BURST)+1  burst length.
- avm_read_o, avm_write_o  out  1  Avalon read and write commands.
- avm_writedata_o  out  32  write data.
- avm_byteenable_o  out  4  byte enables; constant 4'hF.
- avm_waitrequest_i  in  1  slave stall.
- avm_readdata_i  in  32  read data.
- avm_readdatavalid_i  in  1  read data qualifier.

## Operation
- Request packet format:
  - Word 0 is the header: [31:30] op (2'b01 read, 2'b10 write), [15:0] len.
  - Word 1 is the address.
  - A write request is followed by len data words.
- Response packet format:
  - Header: [31:30] op echoed from the request, [29] err, [15:0] len.
  - A read response is the header followed by len data words.
  - A write response, and any error response, is the header only.
- A header is legal when op is 01 or 10 and 1 <= len <= MAX_BURST.
- An illegal header is popped alone, with no address word. The engine sends a header-only response with err=1 and len echoed, and issues no Avalon transaction.
- States and transitions:
  - IDLE: when !req_rdempty_i, pop and latch the header, then go to CHECK.
  - CHECK: if the header is illegal, go to ERR. Otherwise wait for !req_rdempty_i, pop the address, then go to WR_WAIT (write) or RD_SPACE (read).
  - WR_WAIT: wait until req_rdusedw_i >= len, so the burst never starves, then go to WR_DATA.
  - WR_DATA: hold avm_write_o=1 and avm_writedata_o=req_q_i. req_rdreq_o = !avm_waitrequest_i. A beat counter decrements on each accepted beat. After the last accepted beat go to WR_RESP.
  - WR_RESP and ERR: wait until RESP_DEPTH - resp_wrusedw_i >= 1, write the header for one cycle, then go to IDLE.
  - RD_SPACE: wait until RESP_DEPTH - resp_wrusedw_i >= len+1, so read data can never overflow the response FIFO. Then write the response header and go to RD_CMD.
  - RD_CMD: hold avm_read_o=1 until the cycle it is accepted with !avm_waitrequest_i, then go to RD_DATA.
  - RD_DATA: on each avm_readdatavalid_i, forward avm_readdata_i to resp_data_o with resp_valid_o=1 in the next cycle. After len beats go to IDLE.
- avm_address_o and avm_burstcount_o hold the latched values for the whole transaction.
- The beat counter is len-wide and counts down to 1; there is no wrap.

## Timing
- Reset values: all strobe outputs are 0 (req_rdreq_o, resp_valid_o, avm_read_o, avm_write_o). avm_address_o, avm_burstcount_o, avm_writedata_o and resp_data_o are 0. avm_byteenable_o is 4'hF. State is IDLE and the counters are 0.
- Reset asserted mid-transaction aborts immediately: the next cycle shows reset values. Partial packets are not recovered; that is the channel owner's job.
- Header pop happens 1 cycle after !req_rdempty_i is seen in IDLE. Address pop follows 1 cycle later at the earliest.
- Write beats: one beat per cycle while waitrequest is low; a stalled beat holds data and does not pop. The write response header appears at the earliest 1 cycle after the last accepted beat.
- Read data latency through the engine is exactly 1 cycle, readdatavalid to resp_valid_o.
- resp_valid_o is never asserted with a free-space count of 0.
- req_rdreq_o is never asserted while req_rdempty_i=1.
- Simultaneous waitrequest deassertion and a new request arrival: the arrival is ignored until IDLE.

## Test plan
- Single write: header 0x8000_0001, address 0x100, data 0xDEADBEEF, with waitrequest low. Expect one write cycle with addr 0x100, burstcount 1, data 0xDEADBEEF, and response header 0x8000_0001.
- Read burst len 4 at 0x200, with the slave returning 0..3 spaced by random gaps. Expect response 0x4000_0004, 0, 1, 2, 3, each data word 1 cycle after its readdatavalid.
- Write burst len MAX_BURST with waitrequest toggling at random. Expect every data word written exactly once and in order, with pops only on accepted beats.
- Illegal headers 0x0000_0001, 0xC000_0002, 0x8000_0000 and len MAX_BURST+1. Expect one pop each, no Avalon activity, and responses with err=1 (0x2000_0001, 0xE000_0002, ...).
- Response FIFO at RESP_DEPTH-2 used with a read of len 4 pending. Expect avm_read_o held low until usedw drops to RESP_DEPTH-5 or below.
- Reset asserted during the third beat of a write burst. Expect all outputs at reset values the next cycle and a correct subsequent single read.

Source files
------------

// File: rtl/avalon_master_req_engine.sv
// Master-end request engine for the AVMM-over-LVDS bridge.
// Pops request packets from the slave-to-master channel FIFO, replays them as
// Avalon-MM single/burst transactions and pushes one response packet per
// request into the master-to-slave channel FIFO.
module avalon_master_req_engine #(
  // Same value as the bridge package's MAX_BURST.
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned RESP_DEPTH = 2 * MAX_BURST,
  localparam int unsigned BW = $clog2(MAX_BURST) + 1,
  localparam int unsigned RW = $clog2(RESP_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // Request channel (show-ahead FIFO read side)
  output logic          req_rdreq_o,
  input  logic [31:0]   req_q_i,
  input  logic          req_rdempty_i,
  input  logic [BW-1:0] req_rdusedw_i,
  // Response channel (FIFO write side)
  output logic [31:0]   resp_data_o,
  output logic          resp_valid_o,
  input  logic [RW-1:0] resp_wrusedw_i,
  // Avalon-MM master
  output logic [31:0]   avm_address_o,
  output logic [BW-1:0] avm_burstcount_o,
  output logic          avm_read_o,
  output logic          avm_write_o,
  output logic [31:0]   avm_writedata_o,
  output logic [3:0]    avm_byteenable_o,
  input  logic          avm_waitrequest_i,
  input  logic [31:0]   avm_readdata_i,
  input  logic          avm_readdatavalid_i
);

  typedef enum logic [3:0] {
    StIdle,
    StHdr,      // header is popped this cycle, legality decided
    StCheck,    // waiting for / popping the address word
    StWrWait,
    StWrData,
    StWrResp,
    StErr,
    StRdSpace,
    StRdCmd,
    StRdData
  } state_e;

  state_e        state;
  logic [1:0]    op;
  logic [15:0]   len;
  logic [BW-1:0] beats;

  logic          hdr_legal;
  logic [RW-1:0] free_space;
  logic          unused_hdr_bits;

  assign avm_byteenable_o = 4'hF;
  assign free_space       = RW'(RESP_DEPTH) - resp_wrusedw_i;
  assign hdr_legal        = ((op == 2'b01) || (op == 2'b10)) &&
                            (len != 16'd0) && (32'(len) <= MAX_BURST);
  assign unused_hdr_bits  = ^req_q_i[29:16];

  // Write data is the FIFO head itself; zero outside the data phase.
  assign avm_writedata_o = (state == StWrData) ? req_q_i : 32'h0;

  // Pop strobe: header pop, address pop, and one pop per accepted write beat.
  always_comb begin
    req_rdreq_o = 1'b0;
    case (state)
      StHdr:    req_rdreq_o = !req_rdempty_i;
      StCheck:  req_rdreq_o = !req_rdempty_i;
      StWrData: req_rdreq_o = !avm_waitrequest_i && !req_rdempty_i;
      default:  req_rdreq_o = 1'b0;
    endcase
  end

  // Packet sequencer with registered Avalon and response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= StIdle;
      op               <= 2'b00;
      len              <= 16'd0;
      beats            <= '0;
      avm_address_o    <= 32'h0;
      avm_burstcount_o <= '0;
      avm_read_o       <= 1'b0;
      avm_write_o      <= 1'b0;
      resp_valid_o     <= 1'b0;
      resp_data_o      <= 32'h0;
    end else begin
      resp_valid_o <= 1'b0;
      case (state)
        StIdle: begin
          if (!req_rdempty_i) begin
            op    <= req_q_i[31:30];
            len   <= req_q_i[15:0];
            state <= StHdr;
          end
        end
        StHdr: begin
          if (hdr_legal) begin
            avm_burstcount_o <= len[BW-1:0];
            state            <= StCheck;
          end else begin
            state <= StErr;
          end
        end
        StCheck: begin
          if (!req_rdempty_i) begin
            avm_address_o <= req_q_i;
            state         <= (op == 2'b10) ? StWrWait : StRdSpace;
          end
        end
        StWrWait: begin
          // Whole burst already buffered, so the write can never starve.
          if (req_rdusedw_i >= avm_burstcount_o) begin
            avm_write_o <= 1'b1;
            beats       <= avm_burstcount_o;
            state       <= StWrData;
          end
        end
        StWrData: begin
          if (!avm_waitrequest_i) begin
            if (beats == BW'(1)) begin
              avm_write_o <= 1'b0;
              state       <= StWrResp;
            end else begin
              beats <= beats - BW'(1);
            end
          end
        end
        StWrResp, StErr: begin
          if (free_space != '0) begin
            resp_valid_o <= 1'b1;
            resp_data_o  <= {op, (state == StErr), 13'd0, len};
            state        <= StIdle;
          end
        end
        StRdSpace: begin
          // Reserve room for header plus every data beat before reading.
          if (32'(free_space) >= 32'(avm_burstcount_o) + 32'd1) begin
            resp_valid_o <= 1'b1;
            resp_data_o  <= {op, 1'b0, 13'd0, len};
            avm_read_o   <= 1'b1;
            state        <= StRdCmd;
          end
        end
        StRdCmd: begin
          if (!avm_waitrequest_i) begin
            avm_read_o <= 1'b0;
            beats      <= avm_burstcount_o;
            state      <= StRdData;
          end
        end
        StRdData: begin
          if (avm_readdatavalid_i) begin
            resp_valid_o <= 1'b1;
            resp_data_o  <= avm_readdata_i;
            if (beats == BW'(1)) begin
              state <= StIdle;
            end else begin
              beats <= beats - BW'(1);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_master_req_engine.sv
// Directed bench for avalon_master_req_engine with channel FIFO and slave models.
module tb_avalon_master_req_engine;

  localparam int unsigned MAX_BURST  = 8;
  localparam int unsigned RESP_DEPTH = 2 * MAX_BURST;
  localparam int unsigned BW         = $clog2(MAX_BURST) + 1;
  localparam int unsigned RW         = $clog2(RESP_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_rdreq;
  logic [31:0]   req_q = 32'h0;
  logic          req_rdempty = 1'b1;
  logic [BW-1:0] req_rdusedw = '0;
  logic [31:0]   resp_data;
  logic          resp_valid;
  logic [RW-1:0] resp_wrusedw = '0;
  logic [31:0]   avm_address;
  logic [BW-1:0] avm_burstcount;
  logic          avm_read;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   avm_readdata = 32'h0;
  logic          avm_readdatavalid = 1'b0;

  avalon_master_req_engine #(.MAX_BURST(MAX_BURST)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .req_rdreq_o         (req_rdreq),
    .req_q_i             (req_q),
    .req_rdempty_i       (req_rdempty),
    .req_rdusedw_i       (req_rdusedw),
    .resp_data_o         (resp_data),
    .resp_valid_o        (resp_valid),
    .resp_wrusedw_i      (resp_wrusedw),
    .avm_address_o       (avm_address),
    .avm_burstcount_o    (avm_burstcount),
    .avm_read_o          (avm_read),
    .avm_write_o         (avm_write),
    .avm_writedata_o     (avm_writedata),
    .avm_byteenable_o    (avm_byteenable),
    .avm_waitrequest_i   (avm_waitrequest),
    .avm_readdata_i      (avm_readdata),
    .avm_readdatavalid_i (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]   req_fifo[$];
  logic [31:0]   resp_log[$];
  logic [31:0]   wr_log[$];
  int            resp_cyc[$];
  int            rdv_cyc[$];
  int            cyc = 0;
  int            pops, bad_pops, pop_mismatch, rd_cmds, wr_hi, rd_hi;
  int            resp_fill = 0;
  logic [31:0]   rd_addr, wr_addr;
  logic [BW-1:0] rd_bc, wr_bc;

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic clear_logs();
    req_fifo.delete(); resp_log.delete(); wr_log.delete();
    resp_cyc.delete(); rdv_cyc.delete();
    pops = 0; bad_pops = 0; pop_mismatch = 0; rd_cmds = 0; wr_hi = 0; rd_hi = 0;
    rd_addr = 32'h0; wr_addr = 32'h0; rd_bc = '0; wr_bc = '0;
  endtask

  // One clock cycle: drive inputs after negedge, sample and model FIFOs/slave.
  task automatic step(input logic wt, input logic rdv, input logic [31:0] rdd);
    @(negedge clk);
    avm_waitrequest   = wt;
    avm_readdatavalid = rdv;
    avm_readdata      = rdd;
    req_rdempty       = (req_fifo.size() == 0);
    req_q             = req_rdempty ? 32'h0 : req_fifo[0];
    req_rdusedw       = BW'(req_fifo.size());
    resp_wrusedw      = RW'(resp_fill);
    #1;
    if (req_rdreq) begin
      if (req_fifo.size() == 0) bad_pops++;
      else begin void'(req_fifo.pop_front()); pops++; end
    end
    if (avm_write) begin
      wr_hi++;
      if (req_rdreq !== !wt) pop_mismatch++;
      if (!wt) begin
        wr_log.push_back(avm_writedata);
        wr_addr = avm_address;
        wr_bc   = avm_burstcount;
      end
    end
    if (avm_read) begin
      rd_hi++;
      if (!wt) begin rd_cmds++; rd_addr = avm_address; rd_bc = avm_burstcount; end
    end
    if (resp_valid) begin resp_log.push_back(resp_data); resp_cyc.push_back(cyc); end
    if (rdv) rdv_cyc.push_back(cyc);
    cyc++;
  endtask

  task automatic drive_write(input bit rand_wt, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < 300; c++) begin
      step(rand_wt ? ($urandom_range(0, 1) == 1) : 1'b0, 1'b0, 32'h0);
      if (resp_log.size() >= 1) begin timed_out = 1'b0; break; end
    end
  endtask

  // Slave returning base+i for beat i, with random gaps and command stalls.
  task automatic serve_read(input logic [31:0] base, input int n, output bit timed_out);
    int   sent;
    int   gap;
    logic rdv;
    sent = 0; gap = 0; timed_out = 1'b1;
    for (int c = 0; c < 300; c++) begin
      rdv = (rd_cmds > 0) && (sent < n) && (gap == 0);
      step($urandom_range(0, 1) == 1, rdv, base + 32'(sent));
      if (rdv) begin sent++; gap = $urandom_range(0, 2); end
      else if (gap > 0) gap--;
      if (resp_log.size() >= n + 1) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_logs();
    step(1'b0, 1'b0, 32'h0);
    n_cmp++;
    if ({req_rdreq, resp_valid, avm_read, avm_write} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_strobes got=%b want=0000",
                        {req_rdreq, resp_valid, avm_read, avm_write});
    end
    n_cmp++;
    if (avm_address !== 32'h0) begin
      n_bad++; $display("FAIL reset_address got=%h want=0", avm_address);
    end
    n_cmp++;
    if (avm_burstcount !== BW'(0)) begin
      n_bad++; $display("FAIL reset_burstcount got=%h want=0", avm_burstcount);
    end
    n_cmp++;
    if ({avm_writedata, resp_data} !== 64'h0) begin
      n_bad++; $display("FAIL reset_data got=%h/%h want=0/0", avm_writedata, resp_data);
    end
    n_cmp++;
    if (avm_byteenable !== 4'hF) begin
      n_bad++; $display("FAIL reset_byteenable got=%h want=f", avm_byteenable);
    end
    rst = 1'b0;
    step(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_single_write();
    bit to;
    clear_logs();
    req_fifo.push_back(32'h8000_0001);
    req_fifo.push_back(32'h0000_0100);
    req_fifo.push_back(32'hDEAD_BEEF);
    drive_write(1'b0, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL single_write_timeout got=timeout want=response"); end
    n_cmp++;
    if (wr_hi !== 1 || wr_log.size() !== 1) begin
      n_bad++; $display("FAIL single_write_cycles got=%0d/%0d want=1/1", wr_hi, wr_log.size());
    end
    n_cmp++;
    if (qget(wr_log, 0) !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL single_write_data got=%h want=deadbeef", qget(wr_log, 0));
    end
    n_cmp++;
    if ({wr_addr, wr_bc} !== {32'h100, BW'(1)}) begin
      n_bad++; $display("FAIL single_write_addr_bc got=%h/%0d want=100/1", wr_addr, wr_bc);
    end
    n_cmp++;
    if (qget(resp_log, 0) !== 32'h8000_0001 || resp_log.size() !== 1) begin
      n_bad++; $display("FAIL single_write_resp got=%h want=80000001", qget(resp_log, 0));
    end
    n_cmp++;
    if (pops !== 3 || bad_pops !== 0) begin
      n_bad++; $display("FAIL single_write_pops got=%0d/%0d want=3/0", pops, bad_pops);
    end
  endtask

  task automatic test_read_burst();
    bit to;
    logic [31:0] exp_resp[5];
    exp_resp = '{32'h4000_0004, 32'h0, 32'h1, 32'h2, 32'h3};
    clear_logs();
    req_fifo.push_back(32'h4000_0004);
    req_fifo.push_back(32'h0000_0200);
    serve_read(32'h0, 4, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL read_burst_timeout got=timeout want=5 words"); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (qget(resp_log, i) !== exp_resp[i]) begin
        n_bad++; $display("FAIL read_burst_word%0d got=%h want=%h", i, qget(resp_log, i),
                          exp_resp[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i + 1 >= resp_cyc.size() || i >= rdv_cyc.size() ||
          resp_cyc[i+1] - rdv_cyc[i] !== 1) begin
        n_bad++; $display("FAIL read_burst_latency%0d got=mismatch want=1 cycle", i);
      end
    end
    n_cmp++;
    if ({rd_addr, rd_bc} !== {32'h200, BW'(4)} || rd_cmds !== 1) begin
      n_bad++; $display("FAIL read_burst_cmd got=%h/%0d/%0d want=200/4/1", rd_addr, rd_bc,
                        rd_cmds);
    end
  endtask

  task automatic test_write_burst();
    bit to;
    clear_logs();
    req_fifo.push_back(32'h8000_0008);
    req_fifo.push_back(32'h0000_1000);
    for (int i = 0; i < MAX_BURST; i++) req_fifo.push_back(32'hA500_0000 + 32'(i));
    drive_write(1'b1, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL write_burst_timeout got=timeout want=response"); end
    n_cmp++;
    if (wr_log.size() !== MAX_BURST) begin
      n_bad++; $display("FAIL write_burst_count got=%0d want=%0d", wr_log.size(), MAX_BURST);
    end
    for (int i = 0; i < MAX_BURST; i++) begin
      n_cmp++;
      if (qget(wr_log, i) !== 32'hA500_0000 + 32'(i)) begin
        n_bad++; $display("FAIL write_burst_beat%0d got=%h want=%h", i, qget(wr_log, i),
                          32'hA500_0000 + 32'(i));
      end
    end
    n_cmp++;
    if (pops !== 2 + MAX_BURST || bad_pops !== 0 || pop_mismatch !== 0) begin
      n_bad++; $display("FAIL write_burst_pops got=%0d/%0d/%0d want=%0d/0/0", pops, bad_pops,
                        pop_mismatch, 2 + MAX_BURST);
    end
    n_cmp++;
    if ({wr_addr, wr_bc} !== {32'h1000, BW'(MAX_BURST)}) begin
      n_bad++; $display("FAIL write_burst_addr_bc got=%h/%0d want=1000/%0d", wr_addr, wr_bc,
                        MAX_BURST);
    end
    n_cmp++;
    if (qget(resp_log, 0) !== 32'h8000_0008) begin
      n_bad++; $display("FAIL write_burst_resp got=%h want=80000008", qget(resp_log, 0));
    end
  endtask

  task automatic test_illegal();
    logic [31:0] hdr[4];
    logic [31:0] exp_resp[4];
    hdr      = '{32'h0000_0001, 32'hC000_0002, 32'h8000_0000, 32'h8000_0009};
    exp_resp = '{32'h2000_0001, 32'hE000_0002, 32'hA000_0000, 32'hA000_0009};
    for (int k = 0; k < 4; k++) begin
      clear_logs();
      req_fifo.push_back(hdr[k]);
      for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (pops !== 1 || bad_pops !== 0) begin
        n_bad++; $display("FAIL illegal%0d_pops got=%0d/%0d want=1/0", k, pops, bad_pops);
      end
      n_cmp++;
      if (resp_log.size() !== 1 || qget(resp_log, 0) !== exp_resp[k]) begin
        n_bad++; $display("FAIL illegal%0d_resp got=%h (n=%0d) want=%h", k, qget(resp_log, 0),
                          resp_log.size(), exp_resp[k]);
      end
      n_cmp++;
      if (wr_hi + rd_hi !== 0) begin
        n_bad++; $display("FAIL illegal%0d_avalon got=%0d cycles want=0", k, wr_hi + rd_hi);
      end
    end
  endtask

  task automatic test_resp_space();
    bit to;
    clear_logs();
    resp_fill = RESP_DEPTH - 2;
    req_fifo.push_back(32'h4000_0004);
    req_fifo.push_back(32'h0000_0300);
    for (int c = 0; c < 12; c++) step(1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (rd_hi !== 0 || resp_log.size() !== 0) begin
      n_bad++; $display("FAIL space_full got=%0d/%0d want=0/0", rd_hi, resp_log.size());
    end
    resp_fill = RESP_DEPTH - 4;
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (rd_hi !== 0 || resp_log.size() !== 0) begin
      n_bad++; $display("FAIL space_four_free got=%0d/%0d want=0/0", rd_hi, resp_log.size());
    end
    resp_fill = RESP_DEPTH - 5;
    serve_read(32'h50, 4, to);
    n_cmp++;
    if (to || rd_cmds !== 1) begin
      n_bad++; $display("FAIL space_released got=%0d cmds want=1", rd_cmds);
    end
    n_cmp++;
    if (qget(resp_log, 0) !== 32'h4000_0004 || qget(resp_log, 4) !== 32'h53) begin
      n_bad++; $display("FAIL space_resp got=%h..%h want=40000004..00000053",
                        qget(resp_log, 0), qget(resp_log, 4));
    end
    resp_fill = 0;
  endtask

  task automatic test_reset_mid_write();
    bit to;
    clear_logs();
    req_fifo.push_back(32'h8000_0004);
    req_fifo.push_back(32'h0000_2000);
    for (int i = 0; i < 4; i++) req_fifo.push_back(32'hC0DE_0000 + 32'(i));
    to = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step(1'b0, 1'b0, 32'h0);
      if (wr_log.size() == 2) begin to = 1'b0; break; end
    end
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL midreset_setup got=timeout want=2 beats"); end
    step(1'b0, 1'b0, 32'h0);       // third beat on the bus; reset lands on its edge
    rst = 1'b1;
    req_fifo.delete();
    step(1'b0, 1'b0, 32'h0);
    n_cmp++;
    if ({req_rdreq, resp_valid, avm_read, avm_write, avm_address, avm_burstcount,
         avm_writedata, resp_data, avm_byteenable} !==
        {4'b0000, 32'h0, BW'(0), 32'h0, 32'h0, 4'hF}) begin
      n_bad++; $display("FAIL midreset_outputs got=%b%b%b%b %h %h %h %h %h want=0000 0 0 0 0 f",
                        req_rdreq, resp_valid, avm_read, avm_write, avm_address,
                        avm_burstcount, avm_writedata, resp_data, avm_byteenable);
    end
    rst = 1'b0;
    clear_logs();
    req_fifo.push_back(32'h4000_0001);
    req_fifo.push_back(32'h0000_0400);
    serve_read(32'h1234_5678, 1, to);
    n_cmp++;
    if (to || qget(resp_log, 0) !== 32'h4000_0001 || qget(resp_log, 1) !== 32'h1234_5678) begin
      n_bad++; $display("FAIL midreset_read got=%h,%h want=40000001,12345678",
                        qget(resp_log, 0), qget(resp_log, 1));
    end
    n_cmp++;
    if ({rd_addr, rd_bc} !== {32'h400, BW'(1)}) begin
      n_bad++; $display("FAIL midreset_read_cmd got=%h/%0d want=400/1", rd_addr, rd_bc);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_write_burst();
    test_illegal();
    test_resp_space();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
